mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have no parameters; data and address width SHALL be fixed at 16 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 valid  in  1  EX/MEM stage holds a real instruction.
REQ-005 opcode  in  4  instruction opcode from EX/MEM.
REQ-006 alu_out  in  16  effective address from EX/MEM.
REQ-007 store_data  in  16  source-register value for stores.
REQ-008 dmem_read / dmem_write  out  1 each  data-memory request strobes.
REQ-009 dmem_address  out  16  memory address.
REQ-010 dmem_wdata  out  16  memory write data.
REQ-011 dmem_byte_enable  out  2  memory byte lanes; bit1 is the high byte.
REQ-012 dmem_rdata  in  16  memory read data.
REQ-013 dmem_resp  in  1  memory completes the current request in this cycle.
REQ-014 marmux_out  out  16  final access address, feeding the MEM/WB mar register.
REQ-015 mdrmux_out  out  16  loaded or stored data, feeding the MEM/WB mdr register.
REQ-016 stall  out  1  freeze IF/ID/EX/MEM pipeline registers.
REQ-017 mem_wb_load  out  1  load enable for the MEM/WB register.

Function
REQ-018 The memory opcodes SHALL be: LDB 0010, STB 0011, LDW 0110, STW 0111, LDI 1010, STI 1011, and TRAP 1111 (a word read). All other opcodes, and any cycle with valid=0, SHALL be non-memory.
REQ-019 The FSM SHALL have four states: IDLE, ACC1, ACC2, DONE.
REQ-020 IDLE with a non-memory op: stall=0 and mem_wb_load=1 combinationally, the state SHALL remain IDLE, and marmux_out=alu_out, mdrmux_out=store_data pass through.
REQ-021 IDLE with a memory op: stall=1, mem_wb_load=0, and the next state SHALL be ACC1; alu_out and store_data SHALL be captured into internal registers.
REQ-022 ACC1: the block SHALL assert dmem_read (loads, LDI, STI, TRAP) or dmem_write (STB, STW) at the captured address, holding the request stable until dmem_resp.
REQ-023 ACC1 with dmem_resp for LDI/STI: dmem_rdata SHALL be latched as the indirect address, and the next state SHALL be ACC2.
REQ-024 ACC1 with dmem_resp for other ops: the result SHALL be latched, and the next state SHALL be DONE.
REQ-025 ACC2: the block SHALL assert dmem_read (LDI) or dmem_write with store_data (STI) at the indirect address; on dmem_resp it SHALL latch the result and go to DONE.
REQ-026 DONE: stall=0 and mem_wb_load=1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-027 stall SHALL be 1 in ACC1 and ACC2, and mem_wb_load SHALL be 0 in those states.
REQ-028 For word accesses, dmem_address SHALL equal the address with bit0 forced to 0 and dmem_byte_enable=2'b11.
REQ-029 For STB, dmem_wdata SHALL equal {store_data[7:0], store_data[7:0]} and dmem_byte_enable=2'b10 if addr[0]=1, else 2'b01; dmem_address SHALL have bit0 cleared.
REQ-030 LDB SHALL produce mdrmux_out = sign-extension of dmem_rdata[15:8] if addr[0]=1, else of dmem_rdata[7:0].
REQ-031 LDW, LDI and TRAP SHALL produce mdrmux_out=dmem_rdata; stores SHALL produce mdrmux_out = the data written.
REQ-032 In DONE, marmux_out SHALL equal the final access address: the indirect address for LDI/STI, else the captured alu_out with bit0 intact.
REQ-033 dmem_resp in IDLE or DONE SHALL be ignored.
REQ-034 dmem_read and dmem_write SHALL never be asserted together.
REQ-035 Latency: with a single-cycle memory, a single-access op SHALL take 3 cycles from IDLE to IDLE, and an indirect op 4 cycles; each additional wait cycle on dmem_resp SHALL add one cycle.
REQ-036 Inputs SHALL be sampled only in IDLE; input changes during ACC1/ACC2/DONE SHALL have no effect.

Reset
REQ-037 reset SHALL force IDLE asynchronously and clear all internal registers.
REQ-038 While reset is asserted: dmem_read=0, dmem_write=0, dmem_address=0, dmem_wdata=0, dmem_byte_enable=0, stall=0, mem_wb_load=0, marmux_out=0, mdrmux_out=0.
REQ-039 Reset during ACC1/ACC2 SHALL drop the request in the same cycle, and no MEM/WB load SHALL occur for the aborted op.

Verification
REQ-040 LDW: alu_out=0x3001, rdata=0xBEEF, resp in the first ACC1 cycle -> dmem_address=0x3000, be=11, mdrmux_out=0xBEEF, marmux_out=0x3001, mem_wb_load pulses in cycle 3.
REQ-041 LDB: alu_out=0x4001, rdata=0x80FF -> be=11, mdrmux_out=0xFF80; with alu_out=0x4000 -> mdrmux_out=0xFFFF.
REQ-042 STB: alu_out=0x5001, store_data=0x12A5 -> dmem_write=1, wdata=0xA5A5, be=10, address=0x5000.
REQ-043 LDI: alu_out=0x6000; first read returns 0x7002, second returns 0x1234 -> second address=0x7002, mdrmux_out=0x1234, marmux_out=0x7002, 4 cycles total.
REQ-044 STW with resp delayed 3 cycles -> request held stable, stall=1 for 5 cycles, then one mem_wb_load pulse.
REQ-045 Reset asserted mid-ACC2 of STI -> dmem_write drops immediately, all outputs 0, no mem_wb_load; an ADD (0001) applied next -> mem_wb_load=1 in the same cycle.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/response bus between the MEM-stage access controller
// and the data memory.
//   master : controller side - drives the request, receives rdata/resp
//   slave  : memory side     - receives the request, drives rdata/resp
interface mem_access_ctrl_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_read,
    output dmem_write,
    output dmem_address,
    output dmem_wdata,
    output dmem_byte_enable,
    input  dmem_rdata,
    input  dmem_resp
  );

  modport slave (
    input  dmem_read,
    input  dmem_write,
    input  dmem_address,
    input  dmem_wdata,
    input  dmem_byte_enable,
    output dmem_rdata,
    output dmem_resp
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: turns a load/store/indirect/trap instruction
// held in EX/MEM into one or two data-memory transactions, stalls the
// pipeline while they are outstanding and pulses the MEM/WB load when done.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   valid_i         : EX/MEM holds a real instruction
//   opcode_i        : instruction opcode
//   alu_out_i       : effective address
//   store_data_i    : store source data
//   mem             : data-memory bus (master side)
//   marmux_out_o    : final access address to MEM/WB mar
//   mdrmux_out_o    : loaded/stored data to MEM/WB mdr
//   stall_o         : freeze IF/ID/EX/MEM
//   mem_wb_load_o   : MEM/WB load enable
module mem_access_ctrl (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic [3:0]           opcode_i,
  input  logic [15:0]          alu_out_i,
  input  logic [15:0]          store_data_i,
  mem_access_ctrl_if.master    mem,
  output logic [15:0]          marmux_out_o,
  output logic [15:0]          mdrmux_out_o,
  output logic                 stall_o,
  output logic                 mem_wb_load_o
);

  localparam int unsigned W = 16;

  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_LDW  = 4'b0110;
  localparam logic [3:0] OP_STW  = 4'b0111;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t         state_q;
  logic [3:0]     op_q;
  logic           addr_lsb_q;
  logic [W-1:0]   sdata_q;
  logic [W-1:0]   final_addr_q;
  logic [W-1:0]   result_q;
  logic           rd_q;
  logic           wr_q;
  logic [W-1:0]   addr_out_q;
  logic [W-1:0]   wdata_q;
  logic [1:0]     be_q;

  logic           is_mem_d;
  logic           is_dstore_d;
  logic           is_stb_d;
  logic [7:0]     ld_byte_d;
  logic [W-1:0]   acc1_result_d;

  // Instruction decode on the live EX/MEM inputs (only used in IDLE).
  always_comb begin
    is_mem_d    = valid_i && (opcode_i inside {OP_LDB, OP_STB, OP_LDW, OP_STW,
                                               OP_LDI, OP_STI, OP_TRAP});
    is_stb_d    = (opcode_i == OP_STB);
    is_dstore_d = is_stb_d || (opcode_i == OP_STW);
  end

  // Result of the first access for non-indirect ops: stores report the
  // data actually written, byte loads pick the addressed lane and sign-extend.
  always_comb begin
    ld_byte_d = addr_lsb_q ? mem.dmem_rdata[15:8] : mem.dmem_rdata[7:0];
    case (op_q)
      OP_LDB:         acc1_result_d = {{8{ld_byte_d[7]}}, ld_byte_d};
      OP_STB, OP_STW: acc1_result_d = wdata_q;
      default:        acc1_result_d = mem.dmem_rdata;
    endcase
  end

  // Access FSM; the memory request is held in registers so it stays stable
  // across wait cycles and drops asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      addr_lsb_q   <= 1'b0;
      sdata_q      <= '0;
      final_addr_q <= '0;
      result_q     <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_out_q   <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_mem_d) begin
            op_q         <= opcode_i;
            addr_lsb_q   <= alu_out_i[0];
            sdata_q      <= store_data_i;
            final_addr_q <= alu_out_i;
            rd_q         <= !is_dstore_d;
            wr_q         <= is_dstore_d;
            addr_out_q   <= {alu_out_i[W-1:1], 1'b0};
            if (is_stb_d) begin
              wdata_q <= {store_data_i[7:0], store_data_i[7:0]};
              be_q    <= alu_out_i[0] ? 2'b10 : 2'b01;
            end else begin
              wdata_q <= is_dstore_d ? store_data_i : W'(0);
              be_q    <= 2'b11;
            end
            state_q <= ACC1;
          end
        end
        ACC1: begin
          if (mem.dmem_resp) begin
            if (op_q == OP_LDI || op_q == OP_STI) begin
              // Read data is the pointer; reissue as a word access there.
              final_addr_q <= mem.dmem_rdata;
              addr_out_q   <= {mem.dmem_rdata[W-1:1], 1'b0};
              rd_q         <= (op_q == OP_LDI);
              wr_q         <= (op_q == OP_STI);
              wdata_q      <= (op_q == OP_STI) ? sdata_q : W'(0);
              be_q         <= 2'b11;
              state_q      <= ACC2;
            end else begin
              result_q   <= acc1_result_d;
              rd_q       <= 1'b0;
              wr_q       <= 1'b0;
              addr_out_q <= '0;
              wdata_q    <= '0;
              be_q       <= '0;
              state_q    <= DONE;
            end
          end
        end
        ACC2: begin
          if (mem.dmem_resp) begin
            result_q   <= (op_q == OP_LDI) ? mem.dmem_rdata : sdata_q;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_out_q <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            state_q    <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.dmem_read        = rd_q;
  assign mem.dmem_write       = wr_q;
  assign mem.dmem_address     = addr_out_q;
  assign mem.dmem_wdata       = wdata_q;
  assign mem.dmem_byte_enable = be_q;

  // Pipeline control and MEM/WB muxes; IDLE decides in the same cycle so
  // non-memory ops flow through without a bubble. Everything reads 0 in reset.
  always_comb begin
    stall_o       = 1'b0;
    mem_wb_load_o = 1'b0;
    marmux_out_o  = '0;
    mdrmux_out_o  = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          stall_o       = is_mem_d;
          mem_wb_load_o = !is_mem_d;
          marmux_out_o  = alu_out_i;
          mdrmux_out_o  = store_data_i;
        end
        ACC1, ACC2: begin
          stall_o      = 1'b1;
          marmux_out_o = final_addr_q;
          mdrmux_out_o = result_q;
        end
        DONE: begin
          mem_wb_load_o = 1'b1;
          marmux_out_o  = final_addr_q;
          mdrmux_out_o  = result_q;
        end
        default: ;
      endcase
    end
  end

endmodule
